router_input_port: RTL
======================

// Module: router_input_port
// PURPOSE
//  Receive end of the PE->router credit link: accepts 20-bit flits on datain/in_valid into a DEPTH-slot FIFO.
//  Returns one credit pulse (co) per flit that leaves the FIFO, matching the sender's 4-credit counter.
//  Computes the XY route from each head flit, holds it for the packet, and presents flits plus a one-hot output request to the switch.
// PARAMETERS
//  DATA_W   20  flit width
//  DEPTH    4   FIFO slots; equals the sender's initial credit count
//  MY_X     0   this router's x coordinate (2 bits)
//  MY_Y     0   this router's y coordinate (2 bits)
// PORTS
//  clk        in   1       clock, all state on posedge
//  RST        in   1       reset, asynchronous, active-high
//  datain     in   DATA_W  incoming flit
//  in_valid   in   1       datain valid this cycle
//  co         out  1       credit return, 1-cycle pulse per dequeued flit
//  flit_out   out  DATA_W  FIFO front flit
//  flit_valid out  1       flit_out valid and routed
//  flit_ready in   1       switch accepts flit_out this cycle
//  out_req    out  5       one-hot route {L,S,N,W,E}, held for the whole packet
//  ovf_err    out  1       sticky protocol-error flag (see CONFIGURATION)
// BEHAVIOUR
//  Flit format: [19:18] type (00 body, 01 head, 10 tail, 11 single = head+tail), [17:16] dest_x, [15:14] dest_y, [13:0] payload.
//  Reset: co=0, flit_valid=0, out_req=0, ovf_err=0, FSM=IDLE, pointers=0, count=0.
//  Enqueue: a flit is written on the edge where in_valid=1 and count<DEPTH.
//  - in_valid at count==DEPTH: flit dropped and count unchanged, even if a dequeue happens the same cycle.
//  - A credit-correct sender never does this.
//  Dequeue: occurs on the edge where flit_valid & flit_ready. Front pointer advances; count decrements.
//  - co=1 on the following cycle, exactly once per dequeued flit.
//  Simultaneous enqueue+dequeue with count<DEPTH: count unchanged.
//  Pointers wrap modulo DEPTH.
//  FSM IDLE:
//  - FIFO empty: stay IDLE.
//  - Front type 01 or 11: latch the XY route into out_req and go to ACTIVE.
//  - Front type 00 or 10 (headless): discard the flit silently, return its credit, flag an error, stay IDLE.
//  FSM ACTIVE:
//  - flit_valid = (count!=0).
//  - On dequeue of a type 10 or 11 flit: clear out_req and go to IDLE.
//  XY route: dest_x>MY_X -> E; dest_x<MY_X -> W; else dest_y>MY_Y -> N; dest_y<MY_Y -> S; else L.
//  Latency: flit written at edge N is routed at edge N+1; flit_valid is high after edge N+1. Minimum 2 cycles in to out.
//  Back-to-back packets: after a tail dequeue, the next head needs one IDLE cycle to route (1-cycle bubble).
//  Reset mid-packet: all contents and state are discarded immediately; no credits are returned for discarded flits.
//  The sender is reset by the same RST.
// CONFIGURATION
//  Macro RIP_OVF_CHECK_EN.
//  - Defined: ovf_err sets on a full-FIFO write or a headless flit in IDLE, and stays set until RST.
//  - Undefined: ovf_err is tied 0 and the error logic is absent. Drop and discard behaviour is unchanged.
// STRUCTURE
//  Package router_pkg:
//  - flit field bit positions
//  - type encodings FLIT_BODY/HEAD/TAIL/SINGLE
//  - port index constants PORT_E/W/N/S/L
//  - coordinate width
//  Sub-module flit_fifo (DEPTH x DATA_W, count, front read, push/pop); the FSM, routing and credit logic live in this module.
// TESTING
//  1. Reset, then a single flit 0b11_01_00_... at MY=(0,0): out_req=00001 (E) and flit_valid from cycle 2. Dequeue -> co pulse next cycle -> IDLE.
//  2. Head+2 body+tail, flit_ready=1: 4 flits out in order, 4 co pulses, out_req constant until the tail is dequeued.
//  3. flit_ready=0 while sending 4 flits: count=4. A 5th in_valid is dropped and ovf_err=1 (with the macro). Then release ready: exactly 4 flits and 4 co.
//  4. Dest equals MY coords: out_req=10000 (L). Dest y<MY_Y with x equal: out_req=01000 (S).
//  5. Body flit arrives while IDLE: discarded, one co pulse, flit_valid stays 0, ovf_err=1 only when RIP_OVF_CHECK_EN is defined.
//  6. Assert RST with 3 flits buffered in ACTIVE: all outputs return to 0 asynchronously, no co pulses, next packet routes normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared flit layout, type encodings, output-port indices and the XY routing helper
// for the router input port.
package router_pkg;

  localparam int COORD_W = 2;
  localparam int FLIT_W  = 20;

  localparam int TYPE_HI = 19;
  localparam int TYPE_LO = 18;
  localparam int DX_HI   = 17;
  localparam int DX_LO   = 16;
  localparam int DY_HI   = 15;
  localparam int DY_LO   = 14;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam int PORT_E    = 0;
  localparam int PORT_W    = 1;
  localparam int PORT_N    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_L    = 4;
  localparam int NUM_PORTS = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rip_state_e;

  // Dimension-order routing: resolve X completely before Y.
  function automatic logic [NUM_PORTS-1:0] xy_route(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] mx,
    input logic [COORD_W-1:0] my
  );
    logic [NUM_PORTS-1:0] req;
    req = '0;
    if (dx > mx)      req[PORT_E] = 1'b1;
    else if (dx < mx) req[PORT_W] = 1'b1;
    else if (dy > my) req[PORT_N] = 1'b1;
    else if (dy < my) req[PORT_S] = 1'b1;
    else              req[PORT_L] = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with occupancy count; front entry is visible combinationally.
// Storage is not reset; only pointers and count are.
module flit_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/router_input_port.sv
// Credit-based router input port: buffers flits, routes each packet's head (XY), returns credits.
// Optional sticky protocol-error flag enabled by defining RIP_OVF_CHECK_EN.
module router_input_port
  import router_pkg::*;
#(
  parameter int                  DATA_W = 20,
  parameter int                  DEPTH  = 4,
  parameter logic [COORD_W-1:0]  MY_X   = 2'd0,
  parameter logic [COORD_W-1:0]  MY_Y   = 2'd0
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    datain,
  input  logic                 in_valid,
  output logic                 co,
  output logic [DATA_W-1:0]    flit_out,
  output logic                 flit_valid,
  input  logic                 flit_ready,
  output logic [NUM_PORTS-1:0] out_req,
  output logic                 ovf_err
);
  rip_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] out_req_q, out_req_d;
  logic                 co_q;
  logic                 push, pop, empty, full;
  logic [DATA_W-1:0]    front;
  flit_type_e           front_type;
  logic                 front_is_head, front_is_last;

  assign push = in_valid & ~full;

  flit_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (RST),
    .push_i  (push),
    .wdata_i (datain),
    .pop_i   (pop),
    .rdata_o (front),
    .empty_o (empty),
    .full_o  (full)
  );

  assign front_type    = flit_type_e'(front[TYPE_HI:TYPE_LO]);
  assign front_is_head = (front_type == FLIT_HEAD) || (front_type == FLIT_SINGLE);
  assign front_is_last = (front_type == FLIT_TAIL) || (front_type == FLIT_SINGLE);

  // Headless flits in IDLE are popped too, so their credit still goes back to the sender.
  always_comb begin
    state_d   = state_q;
    out_req_d = out_req_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (front_is_head) begin
            out_req_d = xy_route(front[DX_HI:DX_LO], front[DY_HI:DY_LO], MY_X, MY_Y);
            state_d   = ST_ACTIVE;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!empty && flit_ready) begin
          pop = 1'b1;
          if (front_is_last) begin
            out_req_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      out_req_q <= '0;
      co_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_req_q <= out_req_d;
      co_q      <= pop;
    end
  end

`ifdef RIP_OVF_CHECK_EN
  logic err_q;
  logic headless_discard;

  assign headless_discard = (state_q == ST_IDLE) && !empty && !front_is_head;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_q | (in_valid & full) | headless_discard;
  end

  assign ovf_err = err_q;
`else
  assign ovf_err = 1'b0;
`endif

  assign co         = co_q;
  assign flit_out   = front;
  assign flit_valid = (state_q == ST_ACTIVE) && !empty;
  assign out_req    = out_req_q;

endmodule
